writeback_queue: RTL and testbench

Parametrised writeback stage between the ALU and the register bank. It accepts one ALU result per handshake, which carries up to two register writes and one CPSR update. Register writes are buffered in a DEPTH-entry in-order queue and drained to the register bank one per cycle over a valid/accept handshake. Optionally, it reports to decode whether a register still has a write pending.

---
 rtl/writeback_pkg.sv | 21 ++
 rtl/writeback_queue_if.sv | 53 +++++
 rtl/wb_fifo.sv | 79 +++++++
 rtl/writeback_queue.sv | 95 +++++++++
 tb/tb_writeback_queue.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/writeback_pkg.sv
// Shared types and constants for the writeback queue: default widths, the queue entry
// layout and where each destination field sits inside srcDstIn.
package writeback_pkg;

  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefAddrW = 4;

  // srcDstIn carries two ADDR_W-wide destination fields; these are field indices.
  localparam int unsigned SrcDst1Idx = 0;
  localparam int unsigned SrcDst2Idx = 1;

  typedef struct packed {
    logic [DefAddrW-1:0] addr;
    logic [DefDataW-1:0] data;
  } wb_entry_t;

  function automatic int unsigned src_dst_lsb(int unsigned idx, int unsigned addr_w);
    return idx * addr_w;
  endfunction

endpackage

// File: rtl/writeback_queue_if.sv
// ALU-result, regbank-drain and CPSR signals of the writeback queue.
// WB_HAZARD_EN adds the decode hazard probe (addrQuery/pendingOut).
interface writeback_queue_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DEPTH  = 4
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic                  readyIn;
  logic                  triggerOut;
  logic [DATA_W-1:0]     dataIn1;
  logic [DATA_W-1:0]     dataIn2;
  logic [2*ADDR_W-1:0]   srcDstIn;
  logic                  enIn;
  logic                  wIn;
  logic [31:0]           cpsrIn;
  logic                  cpsrWeIn;
  logic [DATA_W-1:0]     dataOut;
  logic [ADDR_W-1:0]     addrOut;
  logic                  triggerOutRB;
  logic                  readyInRB;
  logic [31:0]           cpsrOut;
  logic                  cpsrWeOut;
  logic [CntW-1:0]       countOut;
`ifdef WB_HAZARD_EN
  logic [ADDR_W-1:0]     addrQuery;
  logic                  pendingOut;

  modport master (
    output readyIn, dataIn1, dataIn2, srcDstIn, enIn, wIn, cpsrIn, cpsrWeIn, readyInRB,
           addrQuery,
    input  triggerOut, dataOut, addrOut, triggerOutRB, cpsrOut, cpsrWeOut, countOut,
           pendingOut
  );
  modport slave (
    input  readyIn, dataIn1, dataIn2, srcDstIn, enIn, wIn, cpsrIn, cpsrWeIn, readyInRB,
           addrQuery,
    output triggerOut, dataOut, addrOut, triggerOutRB, cpsrOut, cpsrWeOut, countOut,
           pendingOut
  );
`else
  modport master (
    output readyIn, dataIn1, dataIn2, srcDstIn, enIn, wIn, cpsrIn, cpsrWeIn, readyInRB,
    input  triggerOut, dataOut, addrOut, triggerOutRB, cpsrOut, cpsrWeOut, countOut
  );
  modport slave (
    input  readyIn, dataIn1, dataIn2, srcDstIn, enIn, wIn, cpsrIn, cpsrWeIn, readyInRB,
    output triggerOut, dataOut, addrOut, triggerOutRB, cpsrOut, cpsrWeOut, countOut
  );
`endif

endinterface

// File: rtl/wb_fifo.sv
// Dual-push, single-pop circular buffer. Occupancy is tracked by count, not pointer compare.
// With WB_HAZARD_EN it also exposes storage and a per-slot valid vector.
module wb_fifo
  import writeback_pkg::*;
#(
  parameter int unsigned Depth   = 4,
  parameter type         entry_t = wb_entry_t
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push0_i,
  input  entry_t                     push0_entry_i,
  input  logic                       push1_i,
  input  entry_t                     push1_entry_i,
  input  logic                       pop_i,
  output entry_t                     head_o,
`ifdef WB_HAZARD_EN
  output entry_t                     mem_o [Depth],
  output logic [Depth-1:0]           valid_o,
`endif
  output logic [$clog2(Depth):0]     count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  entry_t          mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [1:0]      n_push;

  always_comb begin
    n_push   = 2'(push0_i) + 2'(push1_i);
    // PtrW-bit arithmetic wraps modulo Depth since Depth is a power of two.
    wr_ptr_d = wr_ptr_q + PtrW'(n_push);
    rd_ptr_d = rd_ptr_q + PtrW'(pop_i);
    count_d  = count_q + CntW'(n_push) - CntW'(pop_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // A lone push1 takes the slot at the write pointer; with both, it lands one behind push0.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (push0_i) mem_q[wr_ptr_q] <= push0_entry_i;
      if (push1_i) mem_q[push0_i ? wr_ptr_q + PtrW'(1) : wr_ptr_q] <= push1_entry_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

`ifdef WB_HAZARD_EN
  logic [PtrW-1:0] offs;

  assign mem_o = mem_q;

  always_comb begin
    offs    = '0;
    valid_o = '0;
    for (int unsigned i = 0; i < Depth; i++) begin
      offs       = PtrW'(i) - rd_ptr_q;
      valid_o[i] = CntW'(offs) < count_q;
    end
  end
`endif

endmodule

// File: rtl/writeback_queue.sv
// Writeback stage: buffers up to two register writes per ALU result, drains one per cycle
// to the regbank and registers CPSR updates. WB_HAZARD_EN enables the pending-write probe.
module writeback_queue
  import writeback_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DEPTH  = 4
) (
  input logic              clk,
  input logic              reset,
  writeback_queue_if.slave bus
);

  localparam int unsigned CntW    = $clog2(DEPTH) + 1;
  localparam int unsigned Dst1Lsb = src_dst_lsb(SrcDst1Idx, ADDR_W);
  localparam int unsigned Dst2Lsb = src_dst_lsb(SrcDst2Idx, ADDR_W);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic [CntW-1:0] count;
  entry_t          head;
  entry_t          entry1, entry2;
  logic            accept, transfer, head_valid, pop;
  logic [31:0]     cpsr_q;
  logic            cpsr_we_q;

  // Two free slots are demanded regardless of enIn/wIn; a same-cycle pop earns no credit.
  assign accept     = !reset && (count <= CntW'(DEPTH - 2));
  assign transfer   = bus.readyIn && accept;
  assign head_valid = !reset && (count != '0);
  assign pop        = head_valid && bus.readyInRB;

  assign entry1 = '{addr: bus.srcDstIn[Dst1Lsb +: ADDR_W], data: bus.dataIn1};
  assign entry2 = '{addr: bus.srcDstIn[Dst2Lsb +: ADDR_W], data: bus.dataIn2};

`ifdef WB_HAZARD_EN
  entry_t           mem [DEPTH];
  logic [DEPTH-1:0] valid;
  logic             pending;
`endif

  wb_fifo #(
    .Depth   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk_i         (clk),
    .rst_i         (reset),
    .push0_i       (transfer && bus.enIn),
    .push0_entry_i (entry1),
    .push1_i       (transfer && bus.wIn),
    .push1_entry_i (entry2),
    .pop_i         (pop),
    .head_o        (head),
`ifdef WB_HAZARD_EN
    .mem_o         (mem),
    .valid_o       (valid),
`endif
    .count_o       (count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      cpsr_q    <= '0;
      cpsr_we_q <= 1'b0;
    end else begin
      cpsr_we_q <= transfer && bus.cpsrWeIn;
      if (transfer && bus.cpsrWeIn) cpsr_q <= bus.cpsrIn;
    end
  end

  assign bus.triggerOut   = accept;
  assign bus.triggerOutRB = head_valid;
  assign bus.dataOut      = head_valid ? head.data : '0;
  assign bus.addrOut      = head_valid ? head.addr : '0;
  assign bus.countOut     = reset ? '0 : count;
  assign bus.cpsrOut      = cpsr_q;
  assign bus.cpsrWeOut    = cpsr_we_q;

`ifdef WB_HAZARD_EN
  // Only committed entries are compared, so same-cycle pushes never flag a hazard.
  always_comb begin
    pending = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid[i] && (mem[i].addr == bus.addrQuery)) pending = 1'b1;
    end
  end

  assign bus.pendingOut = !reset && pending;
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Randomised bench for writeback_queue, checked every cycle against a queue-level model,
// plus hand-computed spot checks for the directed scenarios.
module tb_writeback_queue;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DEPTH  = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic done = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  writeback_queue_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

  writeback_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference model: a plain FIFO of (addr, data) plus the CPSR value and strobe.
  logic [ADDR_W-1:0] mq_addr [$];
  logic [DATA_W-1:0] mq_data [$];
  logic [31:0]       m_cpsr = '0;
  logic              m_cpsr_we = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input logic rdy, input logic en, input logic w, input logic [7:0] sd,
                       input logic [31:0] d1, input logic [31:0] d2, input logic rb);
    bus.readyIn   = rdy;
    bus.enIn      = en;
    bus.wIn       = w;
    bus.srcDstIn  = sd;
    bus.dataIn1   = d1;
    bus.dataIn2   = d2;
    bus.readyInRB = rb;
  endtask

  // Compare process: check at negedge, then advance the model to the next posedge.
  initial begin
    forever begin
      @(negedge clk);
      if (!done) begin
        int  sz;
        logic xfer;
        sz = mq_addr.size();
        chk("triggerOut", 64'(bus.triggerOut), 64'(!reset && sz <= DEPTH - 2));
        chk("triggerOutRB", 64'(bus.triggerOutRB), 64'(!reset && sz != 0));
        chk("countOut", 64'(bus.countOut), reset ? 64'd0 : 64'(sz));
        chk("countBound", 64'(bus.countOut <= DEPTH), 64'd1);
        if (!reset && sz != 0) begin
          chk("addrOut", 64'(bus.addrOut), 64'(mq_addr[0]));
          chk("dataOut", 64'(bus.dataOut), 64'(mq_data[0]));
        end
        if (reset) begin
          chk("addrOutRst", 64'(bus.addrOut), 64'd0);
          chk("dataOutRst", 64'(bus.dataOut), 64'd0);
        end
        chk("cpsrOut", 64'(bus.cpsrOut), 64'(m_cpsr));
        chk("cpsrWeOut", 64'(bus.cpsrWeOut), 64'(m_cpsr_we));
`ifdef WB_HAZARD_EN
        begin
          logic hit;
          hit = 1'b0;
          foreach (mq_addr[i]) if (mq_addr[i] == bus.addrQuery) hit = 1'b1;
          chk("pendingOut", 64'(bus.pendingOut), 64'(!reset && hit));
        end
`endif
        if (reset) begin
          mq_addr.delete();
          mq_data.delete();
          m_cpsr    = '0;
          m_cpsr_we = 1'b0;
        end else begin
          xfer = bus.readyIn && (sz <= DEPTH - 2);
          if (sz != 0 && bus.readyInRB) begin
            void'(mq_addr.pop_front());
            void'(mq_data.pop_front());
          end
          if (xfer && bus.enIn) begin
            mq_addr.push_back(bus.srcDstIn[ADDR_W-1:0]);
            mq_data.push_back(bus.dataIn1);
          end
          if (xfer && bus.wIn) begin
            mq_addr.push_back(bus.srcDstIn[2*ADDR_W-1:ADDR_W]);
            mq_data.push_back(bus.dataIn2);
          end
          m_cpsr_we = xfer && bus.cpsrWeIn;
          if (m_cpsr_we) m_cpsr = bus.cpsrIn;
        end
      end
    end
  end

  initial begin
    drive(1'b0, 1'b0, 1'b0, 8'h00, '0, '0, 1'b0);
    bus.cpsrIn   = '0;
    bus.cpsrWeIn = 1'b0;
`ifdef WB_HAZARD_EN
    bus.addrQuery = '0;
`endif

    // Reset state
    cyc();
    cyc();
    settle();
    chk("rst_count", 64'(bus.countOut), 64'd0);
    chk("rst_trigOut", 64'(bus.triggerOut), 64'd0);
    chk("rst_trigRB", 64'(bus.triggerOutRB), 64'd0);
    chk("rst_cpsr", 64'(bus.cpsrOut), 64'd0);

    // Single write
    reset = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 8'h03, 32'hDEADBEEF, 32'h0, 1'b1);
    settle();
    chk("single_accept", 64'(bus.triggerOut), 64'd1);
    cyc();
    bus.readyIn = 1'b0;
    settle();
    chk("single_valid", 64'(bus.triggerOutRB), 64'd1);
    chk("single_addr", 64'(bus.addrOut), 64'd3);
    chk("single_data", 64'(bus.dataOut), 64'hDEADBEEF);
    cyc();
    settle();
    chk("single_empty", 64'(bus.countOut), 64'd0);

    // Dual write ordering
    drive(1'b1, 1'b1, 1'b1, 8'h52, 32'h11, 32'h22, 1'b1);
    cyc();
    bus.readyIn = 1'b0;
    settle();
    chk("dual_addr0", 64'(bus.addrOut), 64'd2);
    chk("dual_data0", 64'(bus.dataOut), 64'h11);
    cyc();
    settle();
    chk("dual_addr1", 64'(bus.addrOut), 64'd5);
    chk("dual_data1", 64'(bus.dataOut), 64'h22);
    cyc();
    settle();
    chk("dual_empty", 64'(bus.triggerOutRB), 64'd0);

    // Backpressure and full
    drive(1'b1, 1'b1, 1'b1, 8'h10, 32'hA0, 32'hA1, 1'b0);
    cyc();
    drive(1'b1, 1'b1, 1'b1, 8'h32, 32'hA2, 32'hA3, 1'b0);
    settle();
    chk("bp_count2", 64'(bus.countOut), 64'd2);
    chk("bp_accept2", 64'(bus.triggerOut), 64'd1);
    cyc();
    drive(1'b1, 1'b1, 1'b1, 8'h54, 32'hA4, 32'hA5, 1'b0);
    settle();
    chk("bp_count4", 64'(bus.countOut), 64'd4);
    chk("bp_full", 64'(bus.triggerOut), 64'd0);
    cyc();
    bus.readyInRB = 1'b1;
    settle();
    chk("bp_held", 64'(bus.countOut), 64'd4);
    chk("bp_head_data", 64'(bus.dataOut), 64'hA0);
    cyc();
    settle();
    chk("bp_count3", 64'(bus.countOut), 64'd3);
    chk("bp_still_full", 64'(bus.triggerOut), 64'd0);
    cyc();
    settle();
    chk("bp_count2b", 64'(bus.countOut), 64'd2);
    chk("bp_recover", 64'(bus.triggerOut), 64'd1);
    cyc();
    bus.readyIn = 1'b0;
    settle();
    chk("bp_count3b", 64'(bus.countOut), 64'd3);
    chk("bp_data_a3", 64'(bus.dataOut), 64'hA3);
    repeat (6) cyc();

    // CPSR only
    drive(1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0, 1'b1);
    bus.cpsrIn   = 32'h6000_0000;
    bus.cpsrWeIn = 1'b1;
    cyc();
    bus.readyIn  = 1'b0;
    bus.cpsrWeIn = 1'b0;
    settle();
    chk("cpsr_val", 64'(bus.cpsrOut), 64'h6000_0000);
    chk("cpsr_we1", 64'(bus.cpsrWeOut), 64'd1);
    chk("cpsr_noq", 64'(bus.triggerOutRB), 64'd0);
    cyc();
    settle();
    chk("cpsr_we0", 64'(bus.cpsrWeOut), 64'd0);

    // Random traffic with random regbank stalls
    for (int n = 0; n < 300; n++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            8'($urandom), $urandom, $urandom, 1'($urandom_range(0, 9) < 6));
      bus.cpsrIn   = $urandom;
      bus.cpsrWeIn = 1'($urandom_range(0, 3) == 0);
`ifdef WB_HAZARD_EN
      bus.addrQuery = 4'($urandom);
`endif
      cyc();
    end

    // Drain, then hazard probe and mid-operation reset
    drive(1'b0, 1'b0, 1'b0, 8'h00, '0, '0, 1'b1);
    bus.cpsrWeIn = 1'b0;
    repeat (6) cyc();
    drive(1'b1, 1'b1, 1'b0, 8'h07, 32'h77, 32'h0, 1'b0);
`ifdef WB_HAZARD_EN
    bus.addrQuery = 4'd7;
`endif
    cyc();
    bus.readyIn = 1'b0;
`ifdef WB_HAZARD_EN
    settle();
    chk("haz_pending", 64'(bus.pendingOut), 64'd1);
`endif
    cyc();
    bus.readyInRB = 1'b1;
`ifdef WB_HAZARD_EN
    settle();
    chk("haz_popping", 64'(bus.pendingOut), 64'd1);
`endif
    cyc();
    settle();
    chk("haz_empty", 64'(bus.countOut), 64'd0);
`ifdef WB_HAZARD_EN
    chk("haz_cleared", 64'(bus.pendingOut), 64'd0);
`endif
    drive(1'b1, 1'b1, 1'b1, 8'h21, 32'hB1, 32'hB2, 1'b0);
    cyc();
    drive(1'b1, 1'b1, 1'b0, 8'h03, 32'hB3, 32'h0, 1'b0);
    cyc();
    drive(1'b0, 1'b0, 1'b0, 8'h00, '0, '0, 1'b1);
`ifdef WB_HAZARD_EN
    bus.addrQuery = 4'd3;
`endif
    settle();
    chk("mid_count3", 64'(bus.countOut), 64'd3);
    reset = 1'b1;
    settle();
    chk("mid_rst_count", 64'(bus.countOut), 64'd0);
    chk("mid_rst_trigRB", 64'(bus.triggerOutRB), 64'd0);
    chk("mid_rst_data", 64'(bus.dataOut), 64'd0);
`ifdef WB_HAZARD_EN
    chk("mid_rst_pending", 64'(bus.pendingOut), 64'd0);
`endif
    cyc();
    reset = 1'b0;
    settle();
    chk("post_rst_count", 64'(bus.countOut), 64'd0);
    chk("post_rst_trigRB", 64'(bus.triggerOutRB), 64'd0);
    repeat (3) cyc();

    done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
